spread_stats_unit: RTL and testbench
====================================

Name: spread_stats_unit

Overview:
Parametrised successor to the single-spread accumulator. Computes the bid-ask spread (buy - sell) for every accepted match, then keeps these running statistics:
- saturating spread total and match count
- minimum and maximum spread
- sliding-window sum and average over the last WIN_DEPTH matches

Sits between the Matching Engine / FSM Controller and the VGA analytics renderer. Provides a snapshot handshake so the renderer reads a coherent set of statistics per frame.

Parameters:
PRICE_W, 8, width of buy_price/sell_price and of each spread value
SUM_W, 16, width of spread_sum (must be >= PRICE_W)
CNT_W, 16, width of match_count
WIN_DEPTH, 8, sliding-window depth in matches; power of 2, >= 2
WIN_LOG2, log2(WIN_DEPTH), derived; not overridden by instantiators

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear of all statistics
match_flag  in  1  match indication from Matching Engine
enable_count  in  1  counting enable from FSM Controller
buy_price  in  PRICE_W  matched buy price
sell_price  in  PRICE_W  matched sell price
spread_sum  out  SUM_W  saturating total of spreads
match_count  out  CNT_W  saturating count of accepted matches
spread_min  out  PRICE_W  smallest spread since reset/clear
spread_max  out  PRICE_W  largest spread since reset/clear
window_sum  out  PRICE_W+WIN_LOG2  sum of the last min(fill, WIN_DEPTH) spreads
window_avg  out  PRICE_W  window_sum >> WIN_LOG2; valid only when window_full
window_full  out  1  WIN_DEPTH spreads held since reset/clear
sum_ovf  out  1  sticky: spread_sum or match_count saturated
neg_err  out  1  sticky: a match had buy_price < sell_price
snap_req  in  1  snapshot request, one-cycle pulse from renderer
snap_valid  out  1  one-cycle pulse, snapshot registers loaded
snap_sum  out  SUM_W  snapshot of spread_sum
snap_count  out  CNT_W  snapshot of match_count
snap_avg  out  PRICE_W  snapshot of window_avg (0 if window not full)

Behaviour:
- Reset (async): all outputs 0 except spread_min = all ones. The window buffer contents are don't-care; the fill counter is 0.
- Accept condition: match_flag && enable_count sampled at a rising edge.
- Stage 1 (registered):
  - spread = buy_price - sell_price when buy_price >= sell_price.
  - Otherwise spread = 0 and neg_err is set at the stage-2 update.
  - Stage 1 holds spread and a valid bit.
- Stage 2, when valid:
  - spread_sum += spread, saturating at all ones.
  - match_count += 1, saturating at all ones.
  - Either saturation sets sum_ovf.
  - spread_min = min(spread_min, spread); spread_max = max(spread_max, spread).
  - A zero spread is a legal minimum.
- Latency: an event accepted at edge N appears on the statistics outputs after edge N+2. One event per cycle is sustained with no bubbles.
- Window: circular buffer of WIN_DEPTH entries plus write pointer and fill counter.
  - Before full: window_sum += spread.
  - When full: window_sum += spread - oldest entry (the entry at the write pointer), then overwrite it.
  - The write pointer wraps from WIN_DEPTH-1 to 0.
  - window_full asserts on the update that brings fill to WIN_DEPTH and stays set.
  - window_avg reads 0 while window_full is low.
- clear: on the clock edge where clear is high, every statistic, both sticky flags, the fill counter and the write pointer return to reset values. Stage-1 valid is dropped. An event accepted at the same edge is discarded. Snapshot registers are not cleared.
- Snapshot:
  - snap_req high at edge N loads snap_* from the statistics as visible just before edge N. An update landing at edge N is excluded.
  - snap_valid pulses high for the cycle after edge N.
  - snap_* hold until the next request.
  - snap_req together with clear captures the pre-clear values.
  - Back-to-back requests give back-to-back snap_valid pulses.
- Reset mid-operation aborts the pipeline immediately; no partial update survives.

Decomposition:
- Shared package spread_pkg:
  - default widths PRICE_W, SUM_W, CNT_W
  - saturating-add function
  - MIN_INIT constant (all ones)
- One sub-module, spread_window:
  - circular buffer, write pointer, fill counter, running window_sum, window_full
  - ports: clk, reset, clear, in_valid, in_spread, window_sum, window_full
- Top level holds stage 1, the global statistics and the snapshot registers.

Test Plan:
1. Reset, then matches with enable_count=1: (buy,sell) = (100,90), (50,47), (20,20) -> after the last accept +2 cycles: spread_sum=13, match_count=3, spread_min=0, spread_max=10.
2. match_flag=1 with enable_count=0 for 5 cycles, then buy=10, sell=12 accepted -> statistics unchanged through the disabled cycles; after the accept, neg_err=1, match_count=1, spread_sum=0.
3. WIN_DEPTH=8: 8 accepts of spread 4, then 8 of spread 12 -> window_full rises after the 8th update with window_sum=32, window_avg=4; after the 16th, window_sum=96, window_avg=12.
4. SUM_W=8: 30 accepts of spread 10 -> spread_sum holds at 255 from the 26th accept on, sum_ovf=1, match_count=30.
5. Continuous accepts of spread 5; snap_req pulsed at the same edge as an accept -> snap_valid one cycle later; snap_count equals the match_count value before that edge.
6. clear asserted at the same edge as an accept and a snap_req -> all statistics at reset values, that event not counted, snap_* hold the pre-clear values; async reset mid-stream also zeroes the snapshot registers.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared widths and helpers for the spread statistics unit and its window sub-block.
package spread_pkg;

    localparam int unsigned DEF_PRICE_W = 8;
    localparam int unsigned DEF_SUM_W   = 16;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam logic [31:0] MIN_INIT    = '1;

    // Adds two values in a w-bit range (w < 32); bit 32 of the result flags that the true sum
    // exceeded the range and the returned value was clamped to all ones.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/spread_stats_unit_if.sv
// Match input, statistics and snapshot signals between the matching side, the unit and the renderer.
interface spread_stats_unit_if
    import spread_pkg::*;
#(
    parameter int unsigned PRICE_W   = DEF_PRICE_W,
    parameter int unsigned SUM_W     = DEF_SUM_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned WIN_DEPTH = 8
);
    localparam int unsigned WIN_LOG2 = $clog2(WIN_DEPTH);

    logic                        clear;
    logic                        match_flag;
    logic                        enable_count;
    logic [PRICE_W-1:0]          buy_price;
    logic [PRICE_W-1:0]          sell_price;
    logic                        snap_req;

    logic [SUM_W-1:0]            spread_sum;
    logic [CNT_W-1:0]            match_count;
    logic [PRICE_W-1:0]          spread_min;
    logic [PRICE_W-1:0]          spread_max;
    logic [PRICE_W+WIN_LOG2-1:0] window_sum;
    logic [PRICE_W-1:0]          window_avg;
    logic                        window_full;
    logic                        sum_ovf;
    logic                        neg_err;
    logic                        snap_valid;
    logic [SUM_W-1:0]            snap_sum;
    logic [CNT_W-1:0]            snap_count;
    logic [PRICE_W-1:0]          snap_avg;

    modport master (
        output clear, match_flag, enable_count, buy_price, sell_price, snap_req,
        input  spread_sum, match_count, spread_min, spread_max, window_sum, window_avg,
        input  window_full, sum_ovf, neg_err, snap_valid, snap_sum, snap_count, snap_avg
    );

    modport slave (
        input  clear, match_flag, enable_count, buy_price, sell_price, snap_req,
        output spread_sum, match_count, spread_min, spread_max, window_sum, window_avg,
        output window_full, sum_ovf, neg_err, snap_valid, snap_sum, snap_count, snap_avg
    );

endinterface

// File: rtl/spread_window.sv
// Sliding-window sum over the last WIN_DEPTH spreads, kept in a circular buffer.
module spread_window
    import spread_pkg::*;
#(
    parameter int unsigned PRICE_W   = DEF_PRICE_W,
    parameter int unsigned WIN_DEPTH = 8,
    localparam int unsigned WIN_LOG2 = $clog2(WIN_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic [PRICE_W-1:0]          in_spread,
    output logic [PRICE_W+WIN_LOG2-1:0] window_sum,
    output logic                        window_full
);
    localparam int unsigned WSUM_W = PRICE_W + WIN_LOG2;

    logic [PRICE_W-1:0]  buf_q [WIN_DEPTH];
    logic [WIN_LOG2-1:0] ptr_q;
    logic [WIN_LOG2:0]   fill_q;
    logic [WSUM_W-1:0]   sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (clear) begin
            ptr_q  <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (in_valid) begin
            // Power-of-two depth lets the pointer wrap by plain overflow.
            ptr_q <= ptr_q + 1'b1;
            if (!fill_q[WIN_LOG2]) begin
                fill_q <= fill_q + 1'b1;
                sum_q  <= sum_q + WSUM_W'(in_spread);
            end else begin
                sum_q  <= sum_q + WSUM_W'(in_spread) - WSUM_W'(buf_q[ptr_q]);
            end
        end
    end

    // Buffer contents are only read once written, so they need no reset.
    always_ff @(posedge clk) begin
        if (in_valid && !clear) begin
            buf_q[ptr_q] <= in_spread;
        end
    end

    assign window_sum  = sum_q;
    assign window_full = fill_q[WIN_LOG2];

endmodule

// File: rtl/spread_stats_unit.sv
// Bid-ask spread statistics: capture, spread stage, global stats, sliding window and snapshot.
module spread_stats_unit
    import spread_pkg::*;
#(
    parameter int unsigned PRICE_W   = DEF_PRICE_W,
    parameter int unsigned SUM_W     = DEF_SUM_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned WIN_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    spread_stats_unit_if.slave bus
);
    localparam int unsigned WIN_LOG2 = $clog2(WIN_DEPTH);
    localparam int unsigned WSUM_W   = PRICE_W + WIN_LOG2;
    localparam logic [PRICE_W-1:0] MIN_RST = MIN_INIT[PRICE_W-1:0];

    logic               cap_valid_q, s1_valid_q, s1_neg_q;
    logic [PRICE_W-1:0] cap_buy_q, cap_sell_q, s1_spread_q;
    logic [SUM_W-1:0]   sum_q, snap_sum_q;
    logic [CNT_W-1:0]   cnt_q, snap_cnt_q;
    logic [PRICE_W-1:0] min_q, max_q, snap_avg_q, window_avg;
    logic               ovf_q, neg_q, snap_valid_q, window_full;
    logic [WSUM_W-1:0]  window_sum;
    logic [32:0]        sum_add, cnt_add;
    logic               unused_sat_bits;

    // Accepted match is captured first, then reduced to a spread, then folded into the stats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            cap_buy_q   <= '0;
            cap_sell_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_spread_q <= '0;
        end else if (bus.clear) begin
            cap_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
        end else begin
            cap_valid_q <= bus.match_flag && bus.enable_count;
            cap_buy_q   <= bus.buy_price;
            cap_sell_q  <= bus.sell_price;
            s1_valid_q  <= cap_valid_q;
            s1_neg_q    <= cap_buy_q < cap_sell_q;
            s1_spread_q <= (cap_buy_q >= cap_sell_q) ? cap_buy_q - cap_sell_q : '0;
        end
    end

    always_comb begin
        sum_add = sat_add(32'(sum_q), 32'(s1_spread_q), SUM_W);
        cnt_add = sat_add(32'(cnt_q), 32'd1, CNT_W);
    end

    assign unused_sat_bits = ^{sum_add[31:SUM_W], cnt_add[31:CNT_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
            min_q <= MIN_RST;
            max_q <= '0;
            ovf_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (bus.clear) begin
            sum_q <= '0;
            cnt_q <= '0;
            min_q <= MIN_RST;
            max_q <= '0;
            ovf_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (s1_valid_q) begin
            sum_q <= sum_add[SUM_W-1:0];
            cnt_q <= cnt_add[CNT_W-1:0];
            ovf_q <= ovf_q | sum_add[32] | cnt_add[32];
            neg_q <= neg_q | s1_neg_q;
            if (s1_spread_q < min_q) min_q <= s1_spread_q;
            if (s1_spread_q > max_q) max_q <= s1_spread_q;
        end
    end

    spread_window #(
        .PRICE_W  (PRICE_W),
        .WIN_DEPTH(WIN_DEPTH)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.clear),
        .in_valid   (s1_valid_q),
        .in_spread  (s1_spread_q),
        .window_sum (window_sum),
        .window_full(window_full)
    );

    assign window_avg = window_full ? window_sum[WSUM_W-1:WIN_LOG2] : '0;

    // Snapshot samples pre-edge values and deliberately ignores clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_valid_q <= 1'b0;
            snap_sum_q   <= '0;
            snap_cnt_q   <= '0;
            snap_avg_q   <= '0;
        end else begin
            snap_valid_q <= bus.snap_req;
            if (bus.snap_req) begin
                snap_sum_q <= sum_q;
                snap_cnt_q <= cnt_q;
                snap_avg_q <= window_avg;
            end
        end
    end

    assign bus.spread_sum  = sum_q;
    assign bus.match_count = cnt_q;
    assign bus.spread_min  = min_q;
    assign bus.spread_max  = max_q;
    assign bus.window_sum  = window_sum;
    assign bus.window_avg  = window_avg;
    assign bus.window_full = window_full;
    assign bus.sum_ovf     = ovf_q;
    assign bus.neg_err     = neg_q;
    assign bus.snap_valid  = snap_valid_q;
    assign bus.snap_sum    = snap_sum_q;
    assign bus.snap_count  = snap_cnt_q;
    assign bus.snap_avg    = snap_avg_q;

endmodule

// File: tb/tb_spread_stats_unit.sv
// Randomised scoreboard bench for spread_stats_unit against a list-based reference model.
module tb_spread_stats_unit;
    localparam int unsigned PW   = 8;
    localparam int unsigned SW   = 8;
    localparam int unsigned CW   = 16;
    localparam int unsigned WD   = 8;
    localparam int unsigned PMAX = (1 << PW) - 1;
    localparam int unsigned SMAX = (1 << SW) - 1;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spread_stats_unit_if #(.PRICE_W(PW), .SUM_W(SW), .CNT_W(CW), .WIN_DEPTH(WD)) bus ();

    spread_stats_unit #(
        .PRICE_W  (PW),
        .SUM_W    (SW),
        .CNT_W    (CW),
        .WIN_DEPTH(WD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int unsigned sum, cnt, mn, mx, wsum, wfull, wavg, ovf, neg;
    } stats_t;
    typedef struct {
        int unsigned sum, cnt, avg;
    } snap_t;
    typedef struct {
        int unsigned due, sp;
        bit          neg;
    } ev_t;

    int unsigned hist[$];   // spreads that have reached the statistics since reset/clear
    ev_t         pend[$];   // accepted events still in flight
    snap_t       snap_q[$];
    snap_t       held;
    bit          neg_seen;
    int unsigned edge_n;
    int          compared   = 0;
    int          mismatched = 0;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stats_t model_stats();
        stats_t          e;
        longint unsigned tot = 0;
        int unsigned     n   = hist.size();
        e.mn   = PMAX;
        e.mx   = 0;
        e.wsum = 0;
        foreach (hist[i]) begin
            tot += hist[i];
            if (hist[i] < e.mn) e.mn = hist[i];
            if (hist[i] > e.mx) e.mx = hist[i];
            if (i + WD >= n) e.wsum += hist[i];
        end
        e.sum   = (tot > SMAX) ? SMAX : 32'(tot);
        e.cnt   = (n > CMAX) ? CMAX : n;
        e.ovf   = (tot > SMAX || n > CMAX) ? 1 : 0;
        e.wfull = (n >= WD) ? 1 : 0;
        e.wavg  = e.wfull != 0 ? e.wsum / WD : 0;
        e.neg   = neg_seen ? 1 : 0;
        return e;
    endfunction

    // Reference model: events land two edges after acceptance.
    always @(posedge clk or posedge reset) begin
        stats_t e;
        ev_t    ev;
        if (reset) begin
            hist.delete();
            pend.delete();
            snap_q.delete();
            neg_seen = 1'b0;
        end else begin
            edge_n++;
            if (bus.snap_req) begin
                e = model_stats();
                snap_q.push_back('{e.sum, e.cnt, e.wavg});
            end
            if (bus.clear) begin
                hist.delete();
                pend.delete();
                neg_seen = 1'b0;
            end else begin
                while (pend.size() != 0 && pend[0].due == edge_n) begin
                    ev = pend.pop_front();
                    hist.push_back(ev.sp);
                    if (ev.neg) neg_seen = 1'b1;
                end
                if (bus.match_flag && bus.enable_count) begin
                    ev.due = edge_n + 2;
                    ev.neg = bus.buy_price < bus.sell_price;
                    ev.sp  = ev.neg ? 0 : int'(bus.buy_price) - int'(bus.sell_price);
                    pend.push_back(ev);
                end
            end
        end
    end

    // Monitor: statistics every cycle, snapshot against the scoreboard queue.
    always @(negedge clk) begin
        stats_t e;
        if (reset) begin
            held = '{0, 0, 0};
        end else begin
            e = model_stats();
            chk("spread_sum", 32'(bus.spread_sum), e.sum);
            chk("match_count", 32'(bus.match_count), e.cnt);
            chk("spread_min", 32'(bus.spread_min), e.mn);
            chk("spread_max", 32'(bus.spread_max), e.mx);
            chk("window_sum", 32'(bus.window_sum), e.wsum);
            chk("window_full", 32'(bus.window_full), e.wfull);
            chk("window_avg", 32'(bus.window_avg), e.wavg);
            chk("sum_ovf", 32'(bus.sum_ovf), e.ovf);
            chk("neg_err", 32'(bus.neg_err), e.neg);
            chk("snap_valid", 32'(bus.snap_valid), (snap_q.size() != 0) ? 1 : 0);
            if (bus.snap_valid && snap_q.size() != 0) held = snap_q.pop_front();
            chk("snap_sum", 32'(bus.snap_sum), held.sum);
            chk("snap_count", 32'(bus.snap_count), held.cnt);
            chk("snap_avg", 32'(bus.snap_avg), held.avg);
        end
    end

    task automatic cyc(input bit m, input bit en, input int unsigned b, input int unsigned s,
                       input bit snap, input bit clr);
        @(negedge clk);
        bus.match_flag   = m;
        bus.enable_count = en;
        bus.buy_price    = PW'(b);
        bus.sell_price   = PW'(s);
        bus.snap_req     = snap;
        bus.clear        = clr;
    endtask

    task automatic acc(input int unsigned b, input int unsigned s);
        cyc(1'b1, 1'b1, b, s, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int unsigned b, s;
        bus.match_flag   = 1'b0;
        bus.enable_count = 1'b0;
        bus.buy_price    = '0;
        bus.sell_price   = '0;
        bus.snap_req     = 1'b0;
        bus.clear        = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_spread_min", 32'(bus.spread_min), PMAX);
        chk("rst_spread_sum", 32'(bus.spread_sum), 0);
        chk("rst_snap_valid", 32'(bus.snap_valid), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic spreads, including a zero minimum.
        acc(100, 90); acc(50, 47); acc(20, 20);
        idle(3);
        chk("t1_sum", 32'(bus.spread_sum), 13);
        chk("t1_count", 32'(bus.match_count), 3);
        chk("t1_min", 32'(bus.spread_min), 0);
        chk("t1_max", 32'(bus.spread_max), 10);

        // Matches ignored without enable, then a negative match.
        do_clear();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
        chk("t2_disabled_count", 32'(bus.match_count), 0);
        acc(10, 12);
        idle(3);
        chk("t2_neg_err", 32'(bus.neg_err), 1);
        chk("t2_count", 32'(bus.match_count), 1);
        chk("t2_sum", 32'(bus.spread_sum), 0);

        // Window fill and full replacement.
        do_clear();
        for (int i = 0; i < 8; i++) begin s = $urandom_range(0, 200); acc(s + 4, s); end
        idle(3);
        chk("t3_full", 32'(bus.window_full), 1);
        chk("t3_wsum8", 32'(bus.window_sum), 32);
        chk("t3_avg8", 32'(bus.window_avg), 4);
        for (int i = 0; i < 8; i++) begin s = $urandom_range(0, 200); acc(s + 12, s); end
        idle(3);
        chk("t3_wsum16", 32'(bus.window_sum), 96);
        chk("t3_avg16", 32'(bus.window_avg), 12);

        // Sum saturation.
        do_clear();
        for (int i = 0; i < 30; i++) begin s = $urandom_range(0, 200); acc(s + 10, s); end
        idle(3);
        chk("t4_sum", 32'(bus.spread_sum), 255);
        chk("t4_ovf", 32'(bus.sum_ovf), 1);
        chk("t4_count", 32'(bus.match_count), 30);

        // Snapshots during a continuous stream, including back-to-back requests.
        do_clear();
        for (int i = 0; i < 10; i++) begin
            s = $urandom_range(0, 200);
            cyc(1'b1, 1'b1, s + 5, s, (i == 3 || i == 6 || i == 7), 1'b0);
            if (i == 4) begin
                chk("t5_snap_valid", 32'(bus.snap_valid), 1);
                chk("t5_snap_count", 32'(bus.snap_count), 1);
                chk("t5_snap_sum", 32'(bus.snap_sum), 5);
            end
        end

        // Clear together with an accept and a snapshot request.
        cyc(1'b1, 1'b1, 30, 25, 1'b1, 1'b1);
        idle(1);
        chk("t6_snap_count", 32'(bus.snap_count), 8);
        chk("t6_snap_sum", 32'(bus.snap_sum), 40);
        chk("t6_count", 32'(bus.match_count), 0);
        idle(3);
        chk("t6_count_late", 32'(bus.match_count), 0);
        chk("t6_min", 32'(bus.spread_min), PMAX);

        // Asynchronous reset in the middle of a stream.
        acc(60, 20); cyc(1'b1, 1'b1, 70, 20, 1'b1, 1'b0); acc(80, 20);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_count", 32'(bus.match_count), 0);
        chk("t6_rst_snap_count", 32'(bus.snap_count), 0);
        chk("t6_rst_snap_sum", 32'(bus.snap_sum), 0);
        chk("t6_rst_snap_valid", 32'(bus.snap_valid), 0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            s = $urandom_range(0, 240);
            b = ($urandom_range(0, 5) == 0) ? $urandom_range(0, s) : s + $urandom_range(0, 15);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, b, s,
                $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end
        idle(4);
        chk("snap_pending", snap_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
